// File: rtl/adc_eth_pkg.sv
// Shared types and constants for the ADC-to-Ethernet framer.
// The frame layout is header, optional sequence field, then payload.
package adc_eth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    SEQ     = 2'd2,
    PAYLOAD = 2'd3
  } framer_state_t;

  localparam int ETH_HDR_BYTES = 14;
  localparam int SEQ_BYTES     = 4;

  localparam logic [15:0] ETHERTYPE_DEFAULT = 16'h88B5;

  // Byte idx of a 14-byte header, most significant byte first.
  function automatic logic [7:0] hdr_byte(input logic [111:0] hdr, input logic [3:0] idx);
    return 8'(hdr >> (7'd104 - {idx, 3'b000}));
  endfunction

  // Byte idx of a big-endian 32-bit word.
  function automatic logic [7:0] seq_byte(input logic [31:0] seq, input logic [1:0] idx);
    return 8'(seq >> (5'd24 - {idx, 3'b000}));
  endfunction

endpackage

// File: rtl/byte_fifo_fwft.sv
// Single-clock first-word-fall-through byte FIFO with a registered level.
// The head byte is visible on rd_data_o whenever the FIFO is not empty.
module byte_fifo_fwft #(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [7:0]       wr_data_i,
  input  logic             rd_en_i,
  output logic [7:0]       rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             wr_ok;
  logic             rd_ok;

  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_eth_framer.sv
// Packs the ADC byte stream into raw Ethernet frames on an AXI-Stream byte port.
// Define ADC_FRAMER_SEQ_HDR_EN to insert a 4-byte sequence number after the header.
module adc_eth_framer
  import adc_eth_pkg::*;
#(
  parameter int          PAYLOAD_LEN = 1024,
  parameter int          FIFO_DEPTH  = 4096,
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE   = ETHERTYPE_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    din,
  input  logic          din_valid,
  output logic [7:0]    tx_axis_tdata,
  output logic          tx_axis_tvalid,
  input  logic          tx_axis_tready,
  output logic          tx_axis_tlast,
  output logic          tx_axis_tuser,
  output logic          overflow,
  output logic [15:0]   drop_count,
  output logic [31:0]   frame_count,
  output framer_state_t dbg_state
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(PAYLOAD_LEN > ETH_HDR_BYTES ? PAYLOAD_LEN : ETH_HDR_BYTES);

  localparam logic [111:0]      HDR_BITS  = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [IDX_W-1:0]  HDR_LAST  = IDX_W'(ETH_HDR_BYTES - 1);
  localparam logic [IDX_W-1:0]  PAY_LAST  = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [LVL_W-1:0]  START_LVL = LVL_W'(PAYLOAD_LEN);
`ifdef ADC_FRAMER_SEQ_HDR_EN
  localparam logic [IDX_W-1:0]  SEQ_LAST  = IDX_W'(SEQ_BYTES - 1);
  localparam framer_state_t     AFTER_HDR = SEQ;
`else
  localparam framer_state_t     AFTER_HDR = PAYLOAD;
`endif

  if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > FIFO_DEPTH) begin : g_bad_payload_len
    $error("adc_eth_framer: PAYLOAD_LEN must be in 1..FIFO_DEPTH");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("adc_eth_framer: FIFO_DEPTH must be a power of two");
  end

  framer_state_t    state_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      frame_count_q;
  logic             overflow_q;
  logic [15:0]      drop_count_q;
  logic [15:0]      drop_count_d;

  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             pop;
  logic [7:0]       tdata_c;

  byte_fifo_fwft #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (din_valid),
    .wr_data_i (din),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  // Outputs are pure decodes of registered state and the FIFO head, so they
  // hold while stalled and have no combinational path from tready.
  assign tx_axis_tvalid = (state_q != IDLE);
  assign tx_axis_tlast  = (state_q == PAYLOAD) && (idx_q == PAY_LAST);
  assign tx_axis_tuser  = 1'b0;
  assign tx_axis_tdata  = tdata_c;
  assign pop            = (state_q == PAYLOAD) && tx_axis_tready && !fifo_empty;

  always_comb begin
    tdata_c = 8'h00;
    case (state_q)
      HDR:     tdata_c = hdr_byte(HDR_BITS, idx_q[3:0]);
`ifdef ADC_FRAMER_SEQ_HDR_EN
      SEQ:     tdata_c = seq_byte(frame_count_q, idx_q[1:0]);
`endif
      PAYLOAD: tdata_c = fifo_head;
      default: tdata_c = 8'h00;
    endcase
  end

  // frame_count doubles as the sequence number: both start at 0, advance on
  // the final payload beat and wrap at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      frame_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_level >= START_LVL) begin
            state_q <= HDR;
            idx_q   <= '0;
          end
        end
        HDR: begin
          if (tx_axis_tready) begin
            if (idx_q == HDR_LAST) begin
              state_q <= AFTER_HDR;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
`ifdef ADC_FRAMER_SEQ_HDR_EN
        SEQ: begin
          if (tx_axis_tready) begin
            if (idx_q == SEQ_LAST) begin
              state_q <= PAYLOAD;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
`endif
        PAYLOAD: begin
          if (tx_axis_tready) begin
            if (idx_q == PAY_LAST) begin
              state_q       <= IDLE;
              idx_q         <= '0;
              frame_count_q <= frame_count_q + 32'd1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (din_valid && fifo_full && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      if (din_valid && fifo_full) overflow_q <= 1'b1;
      drop_count_q <= drop_count_d;
    end
  end

  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;
  assign frame_count = frame_count_q;
  assign dbg_state   = state_q;

endmodule
